led_status_arbiter: RTL and testbench

Arbitrates the board's single active-low RGB LED between three status sources: a sticky error (e.g. capture FIFO overflow), a transmit-activity pulse (e.g. UART byte sent), and an I2C bus-busy level. It stretches short activity pulses so they are visible and blinks red while an error is latched. It sits between the monitor datapath status strobes and the LED pins, replacing direct wiring of status bits to the LED outputs.

---
 rtl/led_status_arbiter_if.sv | 23 ++
 rtl/led_status_arbiter.sv | 130 +++++++++++++
 tb/tb_led_status_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/led_status_arbiter_if.sv
// Status-strobe inputs and LED outputs of the LED status arbiter.
// The master side drives the status strobes and watches the LEDs; the slave
// side is the arbiter itself.
interface led_status_arbiter_if;
    logic i_err_pulse;
    logic i_act_pulse;
    logic i_busy;
    logic i_clr;
    logic o_led_r;
    logic o_led_g;
    logic o_led_b;
    logic o_err_latched;

    modport master (
        output i_err_pulse, i_act_pulse, i_busy, i_clr,
        input  o_led_r, o_led_g, o_led_b, o_err_latched
    );

    modport slave (
        input  i_err_pulse, i_act_pulse, i_busy, i_clr,
        output o_led_r, o_led_g, o_led_b, o_err_latched
    );
endinterface

// File: rtl/led_status_arbiter.sv
// Drives the single active-low RGB LED from three status sources.
// Priority: latched error (blinking red), stretched activity (green), I2C busy (blue).
// Every output is a flop loaded from the next-state decode, so there is no
// combinational path from the status inputs to the LED pins.
module led_status_arbiter #(
    parameter int STRETCH_CYC = 1200000,
    parameter int BLINK_CYC   = 6000000
) (
    input logic                 i_clk,
    input logic                 i_res_n,
    led_status_arbiter_if.slave bus
);
    localparam int SW = $clog2(STRETCH_CYC + 1);
    // A one-cycle half-period still needs a 1-bit counter to hold its zero.
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYC);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACT  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic            err_reg, err_next;
    logic [SW-1:0]   stretch_reg, stretch_next;
    logic [BW-1:0]   blink_reg, blink_next;
    logic            phase_reg, phase_next;
    logic            led_r_reg, led_r_next;
    logic            led_g_reg, led_g_next;
    logic            led_b_reg, led_b_next;

    // Next error latch (set beats clear) and activity stretch count.
    always_comb begin
        err_next = err_reg;
        if (bus.i_err_pulse) begin
            err_next = 1'b1;
        end else if (bus.i_clr) begin
            err_next = 1'b0;
        end

        stretch_next = stretch_reg;
        if (bus.i_act_pulse) begin
            stretch_next = STRETCH_LOAD;
        end else if (stretch_reg != '0) begin
            stretch_next = stretch_reg - SW'(1);
        end
    end

    // Fixed-priority next state; derived only from next-cycle sources, so any
    // stray state encoding is overwritten on the following edge.
    always_comb begin
        state_next = IDLE;
        if (err_next) begin
            state_next = ERR;
        end else if (stretch_next != '0) begin
            state_next = ACT;
        end else if (bus.i_busy) begin
            state_next = BUSY;
        end
    end

    // Blink timing: restarts lit on ERR entry, free-runs while ERR persists.
    always_comb begin
        blink_next = '0;
        phase_next = 1'b0;
        if (state_next == ERR) begin
            if (state_reg != ERR) begin
                blink_next = '0;
                phase_next = 1'b1;
            end else if (blink_reg == BLINK_LAST) begin
                blink_next = '0;
                phase_next = ~phase_reg;
            end else begin
                blink_next = blink_reg + BW'(1);
                phase_next = phase_reg;
            end
        end
    end

    // LED levels decoded from the next state; at most one LED is ever lit.
    always_comb begin
        led_r_next = 1'b1;
        led_g_next = 1'b1;
        led_b_next = 1'b1;
        case (state_next)
            BUSY:    led_b_next = 1'b0;
            ACT:     led_g_next = 1'b0;
            ERR:     led_r_next = ~phase_next;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch, counters and output flops; reset turns every LED off at once.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            err_reg     <= 1'b0;
            stretch_reg <= '0;
            blink_reg   <= '0;
            phase_reg   <= 1'b0;
            led_r_reg   <= 1'b1;
            led_g_reg   <= 1'b1;
            led_b_reg   <= 1'b1;
        end else begin
            err_reg     <= err_next;
            stretch_reg <= stretch_next;
            blink_reg   <= blink_next;
            phase_reg   <= phase_next;
            led_r_reg   <= led_r_next;
            led_g_reg   <= led_g_next;
            led_b_reg   <= led_b_next;
        end
    end

    assign bus.o_led_r       = led_r_reg;
    assign bus.o_led_g       = led_g_reg;
    assign bus.o_led_b       = led_b_reg;
    assign bus.o_err_latched = err_reg;
endmodule

// File: tb/tb_led_status_arbiter.sv
// Bench for led_status_arbiter: two instances (stretch 4 and 8, blink 3)
// share identical stimulus: directed scenarios followed by random traffic.
// Expected LEDs come from an event-time model: time since the last activity
// pulse, time since entering error, and the error latch rule.
module tb_led_status_arbiter;
    localparam int S_A   = 4;
    localparam int S_B   = 8;
    localparam int BLINK = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    led_status_arbiter_if bus_a ();
    led_status_arbiter_if bus_b ();

    led_status_arbiter #(.STRETCH_CYC(S_A), .BLINK_CYC(BLINK)) dut_a (
        .i_clk  (clk),
        .i_res_n(rst_n),
        .bus    (bus_a)
    );

    led_status_arbiter #(.STRETCH_CYC(S_B), .BLINK_CYC(BLINK)) dut_b (
        .i_clk  (clk),
        .i_res_n(rst_n),
        .bus    (bus_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state: absolute cycle times of the relevant events.
    bit m_err       = 1'b0;
    int m_err_entry = 0;
    bit m_have_act  = 1'b0;
    int m_last_act  = 0;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got rgbe=%b expected rgbe=%b", tag, cyc, got, exp);
        end
    endtask

    // Expected {r,g,b,err_latched} after the current edge.
    function automatic logic [3:0] model_out(input int stretch, input bit busy);
        logic [3:0] o;
        o = 4'b1110;
        if (m_err) begin
            o[3] = (((cyc - m_err_entry) / BLINK) % 2) != 0;
            o[0] = 1'b1;
        end else if (m_have_act && (cyc - m_last_act) < stretch) begin
            o[2] = 1'b0;
        end else if (busy) begin
            o[1] = 1'b0;
        end
        return o;
    endfunction

    function automatic logic [3:0] rgbe_a();
        return {bus_a.o_led_r, bus_a.o_led_g, bus_a.o_led_b, bus_a.o_err_latched};
    endfunction

    function automatic logic [3:0] rgbe_b();
        return {bus_b.o_led_r, bus_b.o_led_g, bus_b.o_led_b, bus_b.o_err_latched};
    endfunction

    task automatic drive(input bit e, input bit a, input bit b, input bit c);
        bus_a.i_err_pulse = e; bus_a.i_act_pulse = a; bus_a.i_busy = b; bus_a.i_clr = c;
        bus_b.i_err_pulse = e; bus_b.i_act_pulse = a; bus_b.i_busy = b; bus_b.i_clr = c;
    endtask

    // One clock of stimulus: drive at negedge, advance model at posedge, check after.
    task automatic step(input bit e, input bit a, input bit b, input bit c);
        bit prev_err;
        @(negedge clk);
        drive(e, a, b, c);
        @(posedge clk);
        cyc++;
        prev_err = m_err;
        m_err = e | (m_err & ~c);
        if (m_err && !prev_err) m_err_entry = cyc;
        if (a) begin
            m_have_act = 1'b1;
            m_last_act = cyc;
        end
        #1;
        check_val("dut_a", rgbe_a(), model_out(S_A, b));
        check_val("dut_b", rgbe_b(), model_out(S_B, b));
        $display("cyc=%0d err=%b act=%b busy=%b clr=%b a_rgbe=%b b_rgbe=%b",
                 cyc, e, a, b, c, rgbe_a(), rgbe_b());
    endtask

    // Asynchronous reset between clock edges, held two cycles, released at negedge.
    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_a", rgbe_a(), 4'b1110);
        check_val("async_rst_b", rgbe_b(), 4'b1110);
        $display("async reset asserted a_rgbe=%b b_rgbe=%b", rgbe_a(), rgbe_b());
        repeat (2) begin
            @(posedge clk);
            #1;
            check_val("rst_hold_a", rgbe_a(), 4'b1110);
            check_val("rst_hold_b", rgbe_b(), 4'b1110);
        end
        m_err      = 1'b0;
        m_have_act = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit busy_lvl;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Idle after reset.
        repeat (3) step(0, 0, 0, 0);

        // Single pulse, then a retrigger two cycles into the stretch.
        step(0, 1, 0, 0);
        repeat (9) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (10) step(0, 0, 0, 0);

        // Priority: busy, activity over busy, error over both.
        repeat (2) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        repeat (10) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        repeat (4) step(0, 1, 1, 0);

        // Blink pattern, then clear with busy present.
        repeat (8) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        repeat (3) step(0, 0, 1, 0);

        // Simultaneous set/clear, both entering ERR and while already in ERR.
        step(1, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);

        // Clear during a live stretch.
        step(0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 0);

        // Reset while red is lit.
        step(1, 0, 1, 0);
        do_reset();
        repeat (3) step(0, 0, 0, 0);

        // Random traffic: rare errors, occasional clears, bursty activity.
        busy_lvl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5, 0) == 0) busy_lvl = ~busy_lvl;
            step($urandom_range(39, 0) == 0,
                 $urandom_range(7, 0) == 0,
                 busy_lvl,
                 $urandom_range(14, 0) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
